pc_fetch_unit: RTL
==================

Name: pc_fetch_unit

Overview:
- Program-counter stage directly upstream of the instruction memory. Drives IAddr and the read strobe RW into that memory.
- Computes the next PC from the control unit's PCSrc selection: sequential, branch, jump or jump-register.
- Stalls on PCWre, parks on a halt instruction, and traps misaligned or out-of-range fetch addresses.
- Keeps a retired-instruction counter for the bench and debug.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset.
- MEM_BYTES, 128, instruction memory size in bytes. The highest legal fetch address is MEM_BYTES-4.

Ports:
- CLK  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- PCWre  input  1  PC write enable from control. 0 = stall (hold PC).
- PCSrc  input  2  next-PC select: 00 PC+4, 01 branch, 10 jump, 11 jump-register.
- Immediate  input  16  branch offset in words, signed.
- JAddr  input  26  jump target field.
- RegJR  input  32  jump-register target (rs value).
- Halt  input  1  decoded halt instruction present at the current IAddr.
- IAddr  output  32  current fetch address to instruction memory.
- RW  output  1  instruction memory read strobe. 1 = read, 0 = idle.
- PC4  output  32  IAddr+4, combinational, for link and writeback.
- NextPC  output  32  selected next address, combinational.
- InstCount  output  32  retired-instruction counter.
- Halted  output  1  1 while in HALT.
- Fault  output  1  1 while in FAULT.
- FaultAddr  output  32  offending NextPC captured on fault entry.

Behaviour:
- Reset (Reset==0, async):
  - State goes to BOOT; IAddr=RESET_PC; RW=0; InstCount=0; Halted=0; Fault=0; FaultAddr=0.
  - Reset applies mid-operation from any state.
- Next-PC arithmetic (combinational, modulo 2^32):
  - PC4 = IAddr+4.
  - 01: PC4 + (sign_extend(Immediate)<<2).
  - 10: {PC4[31:28], JAddr, 2'b00}.
  - 11: RegJR.
- FSM states: BOOT, RUN, HALT, FAULT.
- BOOT:
  - RW=0, IAddr held.
  - Goes to RUN unconditionally on the first rising edge after Reset deasserts.
  - RW=1 from that edge onward.
- RUN: RW=1. Evaluated on each rising edge.
  - PCWre=0: everything held (stall), any number of cycles. Halt is ignored while stalled.
  - PCWre=1 and Halt=1: go to HALT. IAddr held. InstCount increments, because the halt instruction retires.
  - PCWre=1, Halt=0, and NextPC is illegal (NextPC[1:0]!=0 or NextPC>MEM_BYTES-4, unsigned): go to FAULT. FaultAddr<=NextPC; IAddr held; InstCount unchanged.
  - PCWre=1, Halt=0, NextPC legal: IAddr<=NextPC; InstCount+1.
  - Halt has priority over fault in the same cycle.
- HALT: RW=0, Halted=1. Only reset exits this state.
- FAULT: RW=0, Fault=1. Only reset exits this state.
- InstCount saturates at 32'hFFFF_FFFF and does not wrap.
- Halted and Fault are registered state decodes and are never both 1.
- Latency:
  - IAddr changes one edge after PCWre is sampled high.
  - The instruction at the new IAddr is available combinationally from the instruction memory in the same cycle.
- An undefined PCSrc is impossible, because all four encodings are defined.

Decomposition:
- Shared package pc_pkg holds:
  - PCSrc encodings: PC_SEQ=2'b00, PC_BR=2'b01, PC_J=2'b10, PC_JR=2'b11.
  - FSM state encoding: BOOT, RUN, HALT, FAULT.
  - The default RESET_PC.
- One combinational sub-module, next_pc_calc, computes PC4 and NextPC from IAddr, PCSrc, Immediate, JAddr and RegJR.
- pc_fetch_unit keeps the FSM, legality check, counters and registers.

Test Plan:
- Reset then 3 edges with PCWre=1, PCSrc=00 -> BOOT for 1 edge with RW=0, then RW=1; IAddr 0 -> 4 -> 8; InstCount=2.
- IAddr=8, PCSrc=01, Immediate=16'hFFFE -> NextPC=4, IAddr=4 after edge. Then Immediate=16'h0003 -> IAddr=20.
- IAddr=20, PCSrc=10, JAddr=26'h000000C -> IAddr=48. Then PCSrc=11, RegJR=32'h0000_0002 -> Fault=1, FaultAddr=2, IAddr stays 48, RW=0.
- PCWre=0 for 5 cycles with PCSrc=00 and Halt pulsed -> IAddr and InstCount unchanged, Halted=0. PCWre=1, Halt=1 -> Halted=1, RW=0, InstCount+1, IAddr unchanged.
- PCSrc=11, RegJR=128 with MEM_BYTES=128 -> Fault=1, FaultAddr=128. RegJR=124 -> legal, IAddr=124.
- Reset asserted asynchronously mid-cycle while in HALT -> IAddr=0, Halted=0 and InstCount=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared encodings and helpers for the program-counter fetch stage.
package pc_pkg;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_BR  = 2'b01,
    PC_J   = 2'b10,
    PC_JR  = 2'b11
  } pcsrc_e;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_HALT  = 2'b10,
    ST_FAULT = 2'b11
  } pc_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Retired-instruction counter sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential, branch, jump, jump-register.
module next_pc_calc
  import pc_pkg::*;
(
  input  logic [31:0] iaddr,
  input  logic [1:0]  pc_src,
  input  logic [15:0] immediate,
  input  logic [25:0] jaddr,
  input  logic [31:0] reg_jr,
  output logic [31:0] pc4,
  output logic [31:0] next_pc
);

  always_comb begin
    pc4     = iaddr + 32'd4;
    next_pc = pc4;
    unique case (pcsrc_e'(pc_src))
      PC_SEQ:  next_pc = pc4;
      PC_BR:   next_pc = pc4 + {{14{immediate[15]}}, immediate, 2'b00};
      PC_J:    next_pc = {pc4[31:28], jaddr, 2'b00};
      PC_JR:   next_pc = reg_jr;
      default: next_pc = pc4;
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and fetch FSM: stall, halt parking, fetch-address trap, retire count.
module pc_fetch_unit
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int unsigned MEM_BYTES = 128
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        PCWre,
  input  logic [1:0]  PCSrc,
  input  logic [15:0] Immediate,
  input  logic [25:0] JAddr,
  input  logic [31:0] RegJR,
  input  logic        Halt,
  output logic [31:0] IAddr,
  output logic        RW,
  output logic [31:0] PC4,
  output logic [31:0] NextPC,
  output logic [31:0] InstCount,
  output logic        Halted,
  output logic        Fault,
  output logic [31:0] FaultAddr
);

  localparam logic [31:0] MAX_FETCH = 32'(MEM_BYTES) - 32'd4;

  pc_state_e   state_q, state_d;
  logic [31:0] iaddr_q, iaddr_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] faddr_q, faddr_d;
  logic        legal;

  next_pc_calc u_next_pc (
    .iaddr     (iaddr_q),
    .pc_src    (PCSrc),
    .immediate (Immediate),
    .jaddr     (JAddr),
    .reg_jr    (RegJR),
    .pc4       (PC4),
    .next_pc   (NextPC)
  );

  assign legal = (NextPC[1:0] == 2'b00) && (NextPC <= MAX_FETCH);

  always_comb begin
    state_d = state_q;
    iaddr_d = iaddr_q;
    cnt_d   = cnt_q;
    faddr_d = faddr_q;
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        // Halt wins over an illegal target: the halt instruction itself retires.
        if (PCWre) begin
          if (Halt) begin
            state_d = ST_HALT;
            cnt_d   = sat_inc(cnt_q);
          end else if (!legal) begin
            state_d = ST_FAULT;
            faddr_d = NextPC;
          end else begin
            iaddr_d = NextPC;
            cnt_d   = sat_inc(cnt_q);
          end
        end
      end
      ST_HALT:  state_d = ST_HALT;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_BOOT;
      iaddr_q <= RESET_PC;
      cnt_q   <= '0;
      faddr_q <= '0;
    end else begin
      state_q <= state_d;
      iaddr_q <= iaddr_d;
      cnt_q   <= cnt_d;
      faddr_q <= faddr_d;
    end
  end

  assign IAddr     = iaddr_q;
  assign InstCount = cnt_q;
  assign FaultAddr = faddr_q;
  assign RW        = (state_q == ST_RUN);
  assign Halted    = (state_q == ST_HALT);
  assign Fault     = (state_q == ST_FAULT);

endmodule
